// File: rtl/i2c_regfile_arbiter.sv
// I2C-slave-facing register file with a one-entry I2C write slot and a CPU port.
// Pending I2C writes always win the shared write port; CPU accesses fill the gaps.
module i2c_regfile_arbiter #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_i2c_ready,
  input  logic          i_i2c_data_valid,
  input  logic          i_i2c_rd_wr,
  input  logic [7:0]    i_i2c_wdata,
  output logic [7:0]    o_i2c_rdata,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [7:0]    i_cpu_wdata,
  output logic          o_cpu_ack,
  output logic [7:0]    o_cpu_rdata,
  output logic          o_i2c_active,
  output logic          o_i2c_wr_evt
);

  typedef enum logic [1:0] {T_IDLE, T_PTR, T_WDATA, T_RDATA} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [7:0]    regs [DEPTH];
  logic          pend_valid;
  logic [AW-1:0] pend_addr;
  logic [7:0]    pend_data;
  logic          capture;
  logic          cpu_grant;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    capture   = 1'b0;
    if (i_i2c_ready) begin
      state_nxt = T_IDLE;
    end else if (i_i2c_data_valid) begin
      case (state)
        T_IDLE: begin
          if (i_i2c_rd_wr) begin
            state_nxt = T_RDATA;
            ptr_nxt   = ptr + AW'(1);
          end else begin
            state_nxt = T_PTR;
          end
        end
        T_PTR: begin
          if (i_i2c_rd_wr) begin
            state_nxt = T_RDATA;
            ptr_nxt   = ptr + AW'(1);
          end else begin
            state_nxt = T_WDATA;
            ptr_nxt   = i_i2c_wdata[AW-1:0];
          end
        end
        T_WDATA: begin
          if (i_i2c_rd_wr) begin
            state_nxt = T_RDATA;
          end else begin
            capture = 1'b1;
          end
          ptr_nxt = ptr + AW'(1);
        end
        T_RDATA: ptr_nxt = ptr + AW'(1);
        default: state_nxt = T_IDLE;
      endcase
    end
  end

  // Holding off the CPU during a capture keeps I2C-then-CPU ordering on the same address.
  assign cpu_grant = i_cpu_req && !pend_valid && !capture && !o_cpu_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= T_IDLE;
      ptr         <= '0;
      pend_valid  <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= '0;
      o_i2c_rdata <= '0;
      o_cpu_ack   <= 1'b0;
      o_cpu_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      pend_valid <= capture;
      if (capture) begin
        pend_addr <= ptr;
        pend_data <= i_i2c_wdata;
      end
      if (pend_valid) regs[pend_addr] <= pend_data;
      else if (cpu_grant && i_cpu_we) regs[i_cpu_addr] <= i_cpu_wdata;
      o_cpu_ack <= cpu_grant;
      if (cpu_grant && !i_cpu_we) o_cpu_rdata <= regs[i_cpu_addr];
      o_i2c_rdata <= regs[ptr];
    end
  end

  assign o_i2c_active = (state != T_IDLE);
  assign o_i2c_wr_evt = pend_valid;

endmodule

// File: tb/tb_i2c_regfile_arbiter.sv
// Directed bench for i2c_regfile_arbiter: reference model of regs/pointer plus a
// scoreboard queue of expected read bytes for both the I2C and CPU sides.
module tb_i2c_regfile_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_i2c_ready = 1'b0;
  logic       i_i2c_data_valid = 1'b0;
  logic       i_i2c_rd_wr = 1'b0;
  logic [7:0] i_i2c_wdata = '0;
  logic [7:0] o_i2c_rdata;
  logic       i_cpu_req = 1'b0;
  logic       i_cpu_we = 1'b0;
  logic [3:0] i_cpu_addr = '0;
  logic [7:0] i_cpu_wdata = '0;
  logic       o_cpu_ack;
  logic [7:0] o_cpu_rdata;
  logic       o_i2c_active;
  logic       o_i2c_wr_evt;

  i2c_regfile_arbiter #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset),
    .i_i2c_ready(i_i2c_ready), .i_i2c_data_valid(i_i2c_data_valid),
    .i_i2c_rd_wr(i_i2c_rd_wr), .i_i2c_wdata(i_i2c_wdata), .o_i2c_rdata(o_i2c_rdata),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata),
    .o_i2c_active(o_i2c_active), .o_i2c_wr_evt(o_i2c_wr_evt)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int evt_cnt = 0;
  int ack_cnt = 0;

  always @(negedge clk) begin
    if (o_i2c_wr_evt) evt_cnt++;
    if (o_cpu_ack) ack_cnt++;
  end

  typedef enum {M_IDLE, M_PTR, M_WDATA, M_RDATA} mstate_t;
  logic [7:0] mdl [16];
  logic [3:0] mptr = '0;
  mstate_t    mst = M_IDLE;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    mptr = '0;
    mst  = M_IDLE;
  endtask

  // One acknowledge pulse; optionally scoreboard the byte presented at that ack.
  task automatic i2c_dv(input logic rw, input logic [7:0] data, input bit chk_rd);
    logic [7:0] e;
    if (chk_rd) exp_q.push_back(mdl[mptr]);
    i_i2c_rd_wr = rw;
    i_i2c_wdata = data;
    i_i2c_data_valid = 1'b1;
    @(negedge clk);
    if (chk_rd) begin
      e = exp_q.pop_front();
      chk("i2c_rdata_at_ack", o_i2c_rdata, e);
    end
    @(posedge clk);
    #1;
    i_i2c_data_valid = 1'b0;
    case (mst)
      M_IDLE:  if (rw) begin mst = M_RDATA; mptr++; end else mst = M_PTR;
      M_PTR:   if (rw) begin mst = M_RDATA; mptr++; end
               else begin mst = M_WDATA; mptr = data[3:0]; end
      M_WDATA: begin if (rw) mst = M_RDATA; else mdl[mptr] = data; mptr++; end
      default: mptr++;
    endcase
    tick();
    tick();
  endtask

  task automatic i2c_stop();
    i_i2c_ready = 1'b1;
    tick();
    i_i2c_ready = 1'b0;
    mst = M_IDLE;
  endtask

  task automatic cpu_access(input logic we, input logic [3:0] addr, input logic [7:0] data,
                            output int lat);
    logic [7:0] e;
    if (!we) exp_q.push_back(mdl[addr]);
    i_cpu_req = 1'b1;
    i_cpu_we = we;
    i_cpu_addr = addr;
    i_cpu_wdata = data;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!o_cpu_ack && lat < 8);
    i_cpu_req = 1'b0;
    if (!o_cpu_ack) chk("cpu_ack_timeout", 8'(o_cpu_ack), 8'd1);
    if (we) mdl[addr] = data;
    else begin
      e = exp_q.pop_front();
      chk("cpu_rdata", o_cpu_rdata, e);
    end
  endtask

  task automatic cpu_write(input logic [3:0] addr, input logic [7:0] data);
    int lat;
    cpu_access(1'b1, addr, data, lat);
  endtask

  task automatic cpu_read(input logic [3:0] addr);
    int lat;
    cpu_access(1'b0, addr, 8'h00, lat);
  endtask

  initial begin
    int e0, a0, lat1, lat2, wait_n;

    // Reset state
    do_reset();
    tick();
    chk("rst_i2c_rdata", o_i2c_rdata, 8'h00);
    chk("rst_cpu_rdata", o_cpu_rdata, 8'h00);
    chk("rst_cpu_ack", 8'(o_cpu_ack), 8'h00);
    chk("rst_active", 8'(o_i2c_active), 8'h00);
    chk("rst_wr_evt", 8'(o_i2c_wr_evt), 8'h00);
    cpu_read(4'd0);
    for (int i = 0; i < 16; i++) cpu_write(4'(i), 8'(8'hC0 + i));

    // Pointer set then two data bytes
    e0 = evt_cnt;
    i2c_dv(1'b0, 8'h08, 1'b0);
    chk("active_in_txn", 8'(o_i2c_active), 8'h01);
    i2c_dv(1'b0, 8'h03, 1'b0);
    i2c_dv(1'b0, 8'hAA, 1'b0);
    i2c_dv(1'b0, 8'hBB, 1'b0);
    i2c_stop();
    tick();
    chk("wr_evt_count", 8'(evt_cnt - e0), 8'd2);
    chk("active_after_stop", 8'(o_i2c_active), 8'h00);
    chk("ptr5_via_rdata", o_i2c_rdata, mdl[5]);
    cpu_read(4'd3);
    cpu_read(4'd4);

    // Pointer wrap
    i2c_dv(1'b0, 8'h08, 1'b0);
    i2c_dv(1'b0, 8'h0F, 1'b0);
    i2c_dv(1'b0, 8'h11, 1'b0);
    i2c_dv(1'b0, 8'h22, 1'b0);
    i2c_stop();
    tick();
    chk("ptr_wrap_rdata", o_i2c_rdata, mdl[1]);
    cpu_read(4'd15);
    cpu_read(4'd0);

    // Repeated-start read
    cpu_write(4'd2, 8'h10);
    cpu_write(4'd3, 8'h20);
    cpu_write(4'd4, 8'h30);
    i2c_dv(1'b0, 8'h08, 1'b0);
    i2c_dv(1'b0, 8'h02, 1'b0);
    i2c_dv(1'b1, 8'h09, 1'b1);
    i2c_dv(1'b1, 8'h00, 1'b1);
    i2c_dv(1'b1, 8'h00, 1'b1);
    chk("read_final_ptr5", o_i2c_rdata, mdl[5]);
    i2c_stop();

    // CPU write arriving in the I2C commit cycle
    i2c_dv(1'b0, 8'h08, 1'b0);
    i2c_dv(1'b0, 8'h04, 1'b0);
    i_i2c_rd_wr = 1'b0;
    i_i2c_wdata = 8'h99;
    i_i2c_data_valid = 1'b1;
    tick();
    i_i2c_data_valid = 1'b0;
    i_cpu_req = 1'b1;
    i_cpu_we = 1'b1;
    i_cpu_addr = 4'd4;
    i_cpu_wdata = 8'h55;
    chk("commit_wr_evt", 8'(o_i2c_wr_evt), 8'h01);
    tick();
    chk("contention_no_ack_yet", 8'(o_cpu_ack), 8'h00);
    wait_n = 1;
    while (!o_cpu_ack && wait_n < 8) begin
      tick();
      wait_n++;
    end
    i_cpu_req = 1'b0;
    chk("contention_ack_latency", 8'(wait_n), 8'd2);
    mdl[4] = 8'h55;
    mptr = 4'd5;
    i2c_stop();
    cpu_read(4'd4);

    // Reset with capture and CPU grant in the same cycle
    i2c_dv(1'b0, 8'h08, 1'b0);
    i2c_dv(1'b0, 8'h06, 1'b0);
    e0 = evt_cnt;
    a0 = ack_cnt;
    i_i2c_wdata = 8'h77;
    i_i2c_data_valid = 1'b1;
    i_cpu_req = 1'b1;
    i_cpu_we = 1'b1;
    i_cpu_addr = 4'd9;
    i_cpu_wdata = 8'h5A;
    reset = 1'b1;
    tick();
    i_i2c_data_valid = 1'b0;
    i_cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    mptr = '0;
    mst = M_IDLE;
    tick();
    tick();
    chk("rst2_i2c_rdata", o_i2c_rdata, 8'h00);
    chk("rst2_cpu_rdata", o_cpu_rdata, 8'h00);
    chk("rst2_cpu_ack", 8'(o_cpu_ack), 8'h00);
    chk("rst2_active", 8'(o_i2c_active), 8'h00);
    chk("rst2_wr_evt", 8'(o_i2c_wr_evt), 8'h00);
    chk("rst2_no_commit", 8'(evt_cnt - e0), 8'd0);
    chk("rst2_no_ack", 8'(ack_cnt - a0), 8'd0);
    cpu_read(4'd6);
    cpu_read(4'd9);

    // Ready during T_RDATA retains pointer
    cpu_write(4'd7, 8'h70);
    cpu_write(4'd8, 8'h80);
    i2c_dv(1'b0, 8'h08, 1'b0);
    i2c_dv(1'b0, 8'hF6, 1'b0);
    i2c_dv(1'b1, 8'h09, 1'b0);
    chk("rdata_ptr7", o_i2c_rdata, 8'h70);
    i2c_stop();
    chk("active_after_ready", 8'(o_i2c_active), 8'h00);
    tick();
    chk("ptr7_retained", o_i2c_rdata, 8'h70);
    i2c_dv(1'b1, 8'h09, 1'b1);
    chk("ptr8_after_resume", o_i2c_rdata, mdl[8]);
    i2c_stop();

    // Back-to-back CPU reads: one ack every two cycles
    cpu_access(1'b0, 4'd7, 8'h00, lat1);
    cpu_access(1'b0, 4'd8, 8'h00, lat2);
    chk("cpu_lat_first", 8'(lat1), 8'd1);
    chk("cpu_lat_b2b", 8'(lat2), 8'd2);
    tick();
    chk("ack_single_pulse", 8'(o_cpu_ack), 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
